// File: rtl/pwm_pkg.sv
// Shared constants, output-mode encoding and PWM helpers for the PWM peripheral.
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package pwm_pkg;

    // Period counter width; one PWM period is 2**PWM_BITS ticks.
    localparam int PWM_BITS = 8;

    // Number of driven output pins, matching the two 8-bit enable registers.
    localparam int NUM_OUT = 16;

    // Duty code that means "always high", with no low slice at the wrap.
    localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;

    // Last value of the period counter before it wraps to zero.
    localparam logic [PWM_BITS-1:0] PER_LAST = 8'hFF;

    // clk cycles per PWM tick; 13 gives about 3.0 kHz at 10 MHz.
    localparam int DEFAULT_PRESCALE = 13;

    // What a single output pin is driven from.
    typedef enum logic [1:0] {
        OUT_LOW  = 2'd0,
        OUT_HIGH = 2'd1,
        OUT_PWM  = 2'd2
    } out_mode_e;

    // Decode the two enable bits of one pin into its drive mode.
    function automatic out_mode_e out_mode(input logic en_out, input logic en_pwm);
        out_mode_e mode;
        if (!en_out) begin
            mode = OUT_LOW;
        end else if (!en_pwm) begin
            mode = OUT_HIGH;
        end else begin
            mode = OUT_PWM;
        end
        return mode;
    endfunction

    // Shared PWM level for the current period position.
    // Full scale is special-cased so that 0xFF never drops low on count 255.
    function automatic logic pwm_level(input logic [PWM_BITS-1:0] per_cnt,
                                       input logic [PWM_BITS-1:0] duty);
        logic level;
        if (duty == DUTY_FULL) begin
            level = 1'b1;
        end else begin
            level = (per_cnt < duty);
        end
        return level;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Free-running prescaler and 8-bit period counter shared by every PWM output.
// Latency: counters advance each clk; tick/boundary/period_start are combinational on current state.
// Backpressure: none, runs continuously from reset release.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                tick_o,
    output logic [PWM_BITS-1:0] per_cnt_o,
    output logic                boundary_o,
    output logic                period_start_o
);

    // A prescale of 1 still needs a one-bit counter so the compare stays legal.
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    pre_cnt_q;
    logic [PRE_W-1:0]    pre_cnt_d;
    logic [PWM_BITS-1:0] per_cnt_q;
    logic [PWM_BITS-1:0] per_cnt_d;

    // One tick per PRESCALE clks; with PRESCALE = 1 this is every clk.
    assign tick_o = (pre_cnt_q == PRE_MAX);

    // Prescaler wraps on tick, period counter steps on tick and wraps 255 -> 0 naturally.
    always_comb begin
        pre_cnt_d = pre_cnt_q + 1'b1;
        per_cnt_d = per_cnt_q;
        if (tick_o) begin
            pre_cnt_d = '0;
            per_cnt_d = per_cnt_q + 1'b1;
        end
    end

    // Counter state; asynchronous reset restarts the period from tick 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            per_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            per_cnt_q <= per_cnt_d;
        end
    end

    // Last clk of the period: the cycle on which the duty shadow is reloaded.
    assign boundary_o = tick_o && (per_cnt_q == PER_LAST);

    // First clk of the period, including the first clk after reset release.
    assign period_start_o = (pre_cnt_q == '0) && (per_cnt_q == '0);

    assign per_cnt_o = per_cnt_q;

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pins low, high or from a shared PWM waveform, as selected by the SPI register map.
// Latency: 1 clk from enable/timebase state to out and pwm_period_start (both registered together).
// Backpressure: none; inputs are level registers in the same clk domain, sampled every clk.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [7:0]          pwm_duty_cycle,
    output logic [NUM_OUT-1:0]  out,
    output logic                pwm_period_start
);

    logic                tick_w;
    logic                boundary_w;
    logic                period_start_w;
    logic [PWM_BITS-1:0] per_cnt_w;

    logic [PWM_BITS-1:0] duty_sh_q;
    logic [PWM_BITS-1:0] duty_sh_d;
    logic                duty_load_w;
    logic                pwm_w;

    logic [NUM_OUT-1:0]  en_out_w;
    logic [NUM_OUT-1:0]  en_pwm_w;
    logic [NUM_OUT-1:0]  out_d;
    logic [NUM_OUT-1:0]  out_q;
    logic                strobe_d;
    logic                strobe_q;

    pwm_timebase #(
        .PRESCALE       (PRESCALE)
    ) u_timebase (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick_o         (tick_w),
        .per_cnt_o      (per_cnt_w),
        .boundary_o     (boundary_w),
        .period_start_o (period_start_w)
    );

    assign en_out_w = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm_w = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Boundary already implies a tick; qualifying with tick keeps the reload
    // visibly tied to the prescaler edge if the boundary definition ever moves.
    assign duty_load_w = tick_w && boundary_w;

    // Duty shadow only follows the SPI value at the period boundary, so a
    // period in flight never sees a new duty and no runt pulse is produced.
    always_comb begin
        duty_sh_d = duty_sh_q;
        if (duty_load_w) begin
            duty_sh_d = pwm_duty_cycle;
        end
    end

    // Duty shadow register; zero after reset keeps PWM pins low for the first period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh_q <= '0;
        end else begin
            duty_sh_q <= duty_sh_d;
        end
    end

    // Shared waveform for the current period position.
    assign pwm_w = pwm_level(per_cnt_w, duty_sh_q);

    // Per-pin source select: forced low, forced high, or the shared PWM level.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            case (out_mode(en_out_w[i], en_pwm_w[i]))
                OUT_LOW:  out_d[i] = 1'b0;
                OUT_HIGH: out_d[i] = 1'b1;
                OUT_PWM:  out_d[i] = pwm_w;
                default:  out_d[i] = 1'b0;
            endcase
        end
    end

    // The strobe is computed from the same timebase state as out_d so a
    // rising PWM edge on out lands in the same clk as the strobe.
    assign strobe_d = period_start_w;

    // Output pin and strobe registers; reset drops every pin immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            strobe_q <= strobe_d;
        end
    end

    assign out              = out_q;
    assign pwm_period_start = strobe_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral with PRESCALE = 13 (period 3328 clks).
// Latency: a per-clk scoreboard predicts out/strobe at each posedge and compares at the next negedge.
// Backpressure: none; stimulus drives register inputs at negedges.
module tb_pwm_peripheral;

    localparam int P      = 13;
    localparam int PERIOD = 256 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_out = '0;
    logic [15:0] en_pwm = '0;
    logic [7:0]  duty = '0;
    logic [15:0] out;
    logic        strobe;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [15:0] o;
        logic        s;
    } exp_t;

    exp_t        sb_q[$];
    int          t_m = 0;
    logic [7:0]  m_duty = '0;

    pwm_peripheral #(
        .PRESCALE         (P)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en_reg_out_7_0   (en_out[7:0]),
        .en_reg_out_15_8  (en_out[15:8]),
        .en_reg_pwm_7_0   (en_pwm[7:0]),
        .en_reg_pwm_15_8  (en_pwm[15:8]),
        .pwm_duty_cycle   (duty),
        .out              (out),
        .pwm_period_start (strobe)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: position in the period comes from a clk count since reset.
    always @(posedge clk or negedge rst_n) begin : model_step
        int   pre;
        int   per;
        logic pwm;
        exp_t e;
        if (!rst_n) begin
            t_m    = 0;
            m_duty = '0;
            sb_q.delete();
        end else begin
            pre = t_m % P;
            per = t_m / P;
            pwm = (m_duty == 8'hFF) || (per < int'(m_duty));
            e.o = en_out & (~en_pwm | {16{pwm}});
            e.s = (t_m == 0);
            sb_q.push_back(e);
            if (t_m == PERIOD - 1) m_duty = duty;
            t_m = (t_m + 1) % PERIOD;
            if (pre < 0) m_duty = m_duty;
        end
    end

    // Scoreboard compare, away from the active edge.
    always @(negedge clk) begin : sb_check
        exp_t e;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("sb_out", 32'(out), 32'(e.o));
            check_val("sb_strobe", 32'(strobe), 32'(e.s));
        end
    end

    // Measure one full period of out[bit_i] starting at the next sample, which must be the strobe.
    // Duty is rewritten twice mid-period (last write wins at the boundary).
    task automatic measure(input int bit_i, input int exp_hi, input logic [7:0] nxt,
                           output int hi, output logic [15:0] snap0, output logic [15:0] snap_mid);
        int waited;
        int first_low;
        int n_strobe;
        hi        = 0;
        first_low = PERIOD;
        n_strobe  = 0;
        waited    = 0;
        snap0     = '0;
        snap_mid  = '0;
        @(negedge clk);
        while (strobe !== 1'b1 && waited < 2 * PERIOD) begin
            @(negedge clk);
            waited++;
        end
        check_val("strobe_wait", 32'(waited), 32'd0);
        for (int k = 0; k < PERIOD; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 300)  duty = ~nxt;
            if (k == 1000) duty = nxt;
            if (k == 0)    snap0 = out;
            if (k == 2000) snap_mid = out;
            if (strobe === 1'b1) n_strobe++;
            if (out[bit_i] === 1'b1) hi++;
            else if (first_low == PERIOD) first_low = k;
        end
        check_val("hi_clks", 32'(hi), 32'(exp_hi));
        check_val("hi_from_strobe", 32'(first_low), 32'(exp_hi));
        check_val("strobes_per_period", 32'(n_strobe), 32'd1);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          hi;
        logic [15:0] s0;
        logic [15:0] sm;

        repeat (3) @(negedge clk);
        check_val("rst_out", 32'(out), 32'h0);
        check_val("rst_strobe", 32'(strobe), 32'h0);

        // Test 1/2: all pins PWM; first period low, then 50 %, 0 %, 100 %.
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'h80;
        rst_n  = 1'b1;
        measure(0, 0, 8'h80, hi, s0, sm);
        check_val("first_period_out", 32'(s0), 32'h0);
        measure(0, 1664, 8'h00, hi, s0, sm);
        check_val("d80_rise_all", 32'(s0), 32'hFFFF);
        check_val("d80_low_all", 32'(sm), 32'h0);
        measure(0, 0, 8'hFF, hi, s0, sm);
        measure(0, PERIOD, 8'h40, hi, s0, sm);

        // Test 3: mixed enables, changed on the last sample before a period start.
        en_out = 16'h00F0;
        en_pwm = 16'h0030;
        measure(4, 832, 8'h20, hi, s0, sm);
        check_val("mix_start", 32'(s0), 32'h00F0);
        check_val("mix_mid", 32'(sm), 32'h00C0);

        // Test 4: 0x20 period, with 0xC0 written mid-period for the next one.
        measure(4, 416, 8'hC0, hi, s0, sm);
        measure(4, 2496, 8'h01, hi, s0, sm);

        // Test 6: extreme non-zero duties.
        measure(4, 13, 8'hFE, hi, s0, sm);
        measure(4, 3302, 8'h80, hi, s0, sm);
        check_val("fe_low_clks", 32'(PERIOD - hi), 32'd26);
        measure(4, 1664, 8'h80, hi, s0, sm);

        // Test 5: asynchronous reset in the high phase of a period.
        repeat (100) @(negedge clk);
        check_val("pre_rst_high", 32'(out), 32'h00F0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_out", 32'(out), 32'h0);
        check_val("async_rst_strobe", 32'(strobe), 32'h0);
        repeat (4) @(negedge clk);
        check_val("held_rst_out", 32'(out), 32'h0);
        rst_n = 1'b1;
        measure(4, 0, 8'h80, hi, s0, sm);
        check_val("post_rst_first", 32'(s0), 32'h00C0);
        measure(4, 1664, 8'h80, hi, s0, sm);
        check_val("post_rst_second", 32'(s0), 32'h00F0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
